// File: rtl/block_shift_row_if.sv
// block_shift_row_if: signals between the row sequencer/tick divider and one block_shift_row row.
// master drives the row controls; slave is the shifter itself.
interface block_shift_row_if #(
   parameter int ROW_W = 8,
   parameter int LEN_W = 4
);
   logic             adjClkPulse;
   logic             start;
   logic             stopBtn;
   logic [LEN_W-1:0] blkLen;
   logic [ROW_W-1:0] baseRow;
   logic [ROW_W-1:0] newBlockLoc;
   logic [ROW_W-1:0] placedRow;
   logic [LEN_W-1:0] placedLen;
   logic             startNext;
   logic             done;
   logic             miss;
   modport master (
      output adjClkPulse, start, stopBtn, blkLen, baseRow,
      input  newBlockLoc, placedRow, placedLen, startNext, done, miss
   );
   modport slave (
      input  adjClkPulse, start, stopBtn, blkLen, baseRow,
      output newBlockLoc, placedRow, placedLen, startNext, done, miss
   );
endinterface

// File: rtl/block_shift_row.sv
// block_shift_row: sweeps a lit run across a row, then trims it against the row below on stop.
// Define BLOCK_SHIFT_WRAP_EN to rotate the run rightwards instead of bouncing at the edges.
module block_shift_row #(
   parameter int ROW_W = 8,
   parameter int LEN_W = 4
) (
   input logic              clk,
   input logic              rst,
   block_shift_row_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, MISS} state_t;
   localparam logic [LEN_W-1:0] ROW_L = LEN_W'(ROW_W);
   state_t           state_q, state_d;
   logic [ROW_W-1:0] loc_q, loc_d, placed_q, placed_d, trim;
   logic [LEN_W-1:0] len_q, len_d, plen_q, plen_d, clamp, trim_cnt;
   logic             stop_prev_q, stop_rise;
   logic             done_q, done_d, next_q, next_d, miss_q, miss_d;
`ifndef BLOCK_SHIFT_WRAP_EN
   logic             left_q, left_d;
`endif
   assign stop_rise = bus.stopBtn & ~stop_prev_q;
   assign clamp = (bus.blkLen == '0) ? LEN_W'(1) : ((bus.blkLen > ROW_L) ? ROW_L : bus.blkLen);
   assign trim = loc_q & bus.baseRow;
   always_comb begin
      trim_cnt = '0;
      for (int i = 0; i < ROW_W; i++) trim_cnt = trim_cnt + LEN_W'(trim[i]);
   end
   always_comb begin
      state_d  = state_q;
      loc_d    = loc_q;
      placed_d = placed_q;
      plen_d   = plen_q;
      len_d    = len_q;
      done_d   = 1'b0;
      next_d   = next_q;
      miss_d   = miss_q;
`ifndef BLOCK_SHIFT_WRAP_EN
      left_d   = left_q;
`endif
      if (!bus.start) begin
         state_d = IDLE;
         loc_d   = '0;
         next_d  = 1'b0;
         miss_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = SHIFT;
               loc_d    = ~({ROW_W{1'b1}} >> clamp);
               placed_d = '0;
               plen_d   = '0;
               len_d    = clamp;
`ifndef BLOCK_SHIFT_WRAP_EN
               left_d   = 1'b0;
`endif
            end
            SHIFT: begin
               if (stop_rise) state_d = CHECK;
               else if (bus.adjClkPulse && len_q != ROW_L) begin
`ifdef BLOCK_SHIFT_WRAP_EN
                  loc_d = {loc_q[0], loc_q[ROW_W-1:1]};
`else
                  // the bounce flips direction and steps the new way in the same tick
                  left_d = (left_q ? loc_q[ROW_W-1] : loc_q[0]) ? ~left_q : left_q;
                  loc_d  = left_d ? loc_q << 1 : loc_q >> 1;
`endif
               end
            end
            CHECK: begin
               placed_d = trim;
               plen_d   = trim_cnt;
               loc_d    = trim;
               state_d  = |trim ? DONE : MISS;
               done_d   = |trim;
               next_d   = |trim;
               miss_d   = ~|trim;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         loc_q       <= '0;
         placed_q    <= '0;
         plen_q      <= '0;
         len_q       <= '0;
         done_q      <= 1'b0;
         next_q      <= 1'b0;
         miss_q      <= 1'b0;
         stop_prev_q <= 1'b0;
`ifndef BLOCK_SHIFT_WRAP_EN
         left_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         loc_q       <= loc_d;
         placed_q    <= placed_d;
         plen_q      <= plen_d;
         len_q       <= len_d;
         done_q      <= done_d;
         next_q      <= next_d;
         miss_q      <= miss_d;
         stop_prev_q <= bus.stopBtn;
`ifndef BLOCK_SHIFT_WRAP_EN
         left_q      <= left_d;
`endif
      end
   end
   assign bus.newBlockLoc = loc_q;
   assign bus.placedRow   = placed_q;
   assign bus.placedLen   = plen_q;
   assign bus.startNext   = next_q;
   assign bus.done        = done_q;
   assign bus.miss        = miss_q;
endmodule

// File: tb/tb_block_shift_row.sv
// tb_block_shift_row: directed-vector bench for block_shift_row with ROW_W=8, LEN_W=4.
module tb_block_shift_row;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   block_shift_row_if #(.ROW_W(8), .LEN_W(4)) bus ();
   block_shift_row #(.ROW_W(8), .LEN_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic tick();
      bus.adjClkPulse = 1'b1;
      step(1);
      bus.adjClkPulse = 1'b0;
   endtask
   task automatic begin_row(input logic [3:0] len);
      bus.blkLen = len;
      bus.start  = 1'b1;
      step(1);
   endtask
   task automatic end_row();
      bus.start   = 1'b0;
      bus.stopBtn = 1'b0;
      step(1);
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.adjClkPulse = 1'b0;
      bus.start = 1'b0;
      bus.stopBtn = 1'b0;
      bus.blkLen = 4'd3;
      bus.baseRow = 8'hFF;
      step(2);
      n_cmp++;
      if ({bus.newBlockLoc, bus.placedRow, bus.placedLen, bus.startNext, bus.done, bus.miss} !== 31'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got loc=%b placed=%b len=%0d next=%b done=%b miss=%b want all 0",
                  bus.newBlockLoc, bus.placedRow, bus.placedLen, bus.startNext, bus.done, bus.miss);
      end
      rst = 1'b0;
      step(1);
   endtask
   task automatic test_sweep();
      logic [7:0] exp_loc [8];
`ifdef BLOCK_SHIFT_WRAP_EN
      exp_loc = '{8'b11100000, 8'b01110000, 8'b00111000, 8'b00011100, 8'b00001110, 8'b00000111, 8'b10000011, 8'b11000001};
`else
      exp_loc = '{8'b11100000, 8'b01110000, 8'b00111000, 8'b00011100, 8'b00001110, 8'b00000111, 8'b00001110, 8'b00011100};
`endif
      begin_row(4'd3);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         n_cmp++;
         if (bus.newBlockLoc !== exp_loc[k]) begin
            n_bad++;
            $display("FAIL sweep_tick%0d: got %b want %b", k, bus.newBlockLoc, exp_loc[k]);
         end
      end
      step(2);
      n_cmp++;
      if (bus.newBlockLoc !== exp_loc[7]) begin
         n_bad++;
         $display("FAIL sweep_hold: got %b want %b", bus.newBlockLoc, exp_loc[7]);
      end
      end_row();
   endtask
   task automatic test_stop_hit(input logic [7:0] base, input logic [7:0] exp_row, input logic [3:0] exp_len);
      bus.baseRow = base;
      begin_row(4'd3);
      repeat (3) tick();
      bus.stopBtn = 1'b1;
      step(1);
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL hit_done_early: got %b want 0", bus.done);
      end
      step(1);
      n_cmp++;
      if ({bus.placedRow, bus.placedLen, bus.newBlockLoc, bus.done, bus.startNext, bus.miss} !== {exp_row, exp_len, exp_row, 3'b110}) begin
         n_bad++;
         $display("FAIL hit_result: got placed=%b len=%0d loc=%b done=%b next=%b miss=%b want placed=%b len=%0d loc=%b done=1 next=1 miss=0",
                  bus.placedRow, bus.placedLen, bus.newBlockLoc, bus.done, bus.startNext, bus.miss, exp_row, exp_len, exp_row);
      end
      step(1);
      n_cmp++;
      if ({bus.done, bus.startNext} !== 2'b01) begin
         n_bad++;
         $display("FAIL hit_done_pulse: got done=%b next=%b want done=0 next=1", bus.done, bus.startNext);
      end
      end_row();
      n_cmp++;
      if ({bus.startNext, bus.newBlockLoc, bus.placedRow, bus.placedLen} !== {1'b0, 8'd0, exp_row, exp_len}) begin
         n_bad++;
         $display("FAIL hit_release: got next=%b loc=%b placed=%b len=%0d want next=0 loc=0 placed=%b len=%0d",
                  bus.startNext, bus.newBlockLoc, bus.placedRow, bus.placedLen, exp_row, exp_len);
      end
   endtask
   task automatic test_miss();
      bus.baseRow = 8'b00000011;
      begin_row(4'd3);
      bus.stopBtn = 1'b1;
      step(2);
      n_cmp++;
      if ({bus.miss, bus.startNext, bus.done, bus.placedLen, bus.newBlockLoc} !== {3'b100, 4'd0, 8'd0}) begin
         n_bad++;
         $display("FAIL miss_result: got miss=%b next=%b done=%b len=%0d loc=%b want miss=1 next=0 done=0 len=0 loc=0",
                  bus.miss, bus.startNext, bus.done, bus.placedLen, bus.newBlockLoc);
      end
      end_row();
      n_cmp++;
      if (bus.miss !== 1'b0) begin
         n_bad++;
         $display("FAIL miss_clear: got %b want 0", bus.miss);
      end
   endtask
   task automatic test_stop_edge();
      bus.baseRow = 8'hFF;
      begin_row(4'd3);
      tick();
      bus.stopBtn = 1'b1;
      bus.adjClkPulse = 1'b1;
      step(1);
      bus.adjClkPulse = 1'b0;
      n_cmp++;
      if (bus.newBlockLoc !== 8'b01110000) begin
         n_bad++;
         $display("FAIL coincident_noshift: got %b want 01110000", bus.newBlockLoc);
      end
      step(1);
      n_cmp++;
      if ({bus.placedRow, bus.placedLen, bus.done} !== {8'b01110000, 4'd3, 1'b1}) begin
         n_bad++;
         $display("FAIL coincident_placed: got placed=%b len=%0d done=%b want 01110000 3 1", bus.placedRow, bus.placedLen, bus.done);
      end
      bus.start = 1'b0;
      step(1);
      begin_row(4'd3);
      repeat (2) tick();
      step(3);
      n_cmp++;
      if ({bus.newBlockLoc, bus.startNext, bus.miss} !== {8'b00111000, 2'b00}) begin
         n_bad++;
         $display("FAIL held_stop: got loc=%b next=%b miss=%b want loc=00111000 next=0 miss=0", bus.newBlockLoc, bus.startNext, bus.miss);
      end
      bus.stopBtn = 1'b0;
      step(1);
      bus.stopBtn = 1'b1;
      step(2);
      n_cmp++;
      if ({bus.done, bus.placedRow, bus.placedLen} !== {1'b1, 8'b00111000, 4'd3}) begin
         n_bad++;
         $display("FAIL repress_stop: got done=%b placed=%b len=%0d want 1 00111000 3", bus.done, bus.placedRow, bus.placedLen);
      end
      end_row();
   endtask
   task automatic test_abort_reset_clamp();
      begin_row(4'd3);
      tick();
      bus.start = 1'b0;
      step(1);
      n_cmp++;
      if ({bus.newBlockLoc, bus.startNext} !== 9'd0) begin
         n_bad++;
         $display("FAIL abort: got loc=%b next=%b want 0 0", bus.newBlockLoc, bus.startNext);
      end
      begin_row(4'd3);
      n_cmp++;
      if (bus.newBlockLoc !== 8'b11100000) begin
         n_bad++;
         $display("FAIL abort_reload: got %b want 11100000", bus.newBlockLoc);
      end
      bus.stopBtn = 1'b1;
      step(3);
      rst = 1'b1;
      bus.start = 1'b0;
      bus.stopBtn = 1'b0;
      step(1);
      n_cmp++;
      if ({bus.newBlockLoc, bus.placedRow, bus.placedLen, bus.startNext, bus.done, bus.miss} !== 31'd0) begin
         n_bad++;
         $display("FAIL reset_in_done: got loc=%b placed=%b len=%0d next=%b done=%b miss=%b want all 0",
                  bus.newBlockLoc, bus.placedRow, bus.placedLen, bus.startNext, bus.done, bus.miss);
      end
      rst = 1'b0;
      step(1);
      begin_row(4'd0);
      n_cmp++;
      if (bus.newBlockLoc !== 8'b10000000) begin
         n_bad++;
         $display("FAIL len0_load: got %b want 10000000", bus.newBlockLoc);
      end
      tick();
      n_cmp++;
      if (bus.newBlockLoc !== 8'b01000000) begin
         n_bad++;
         $display("FAIL len0_step: got %b want 01000000", bus.newBlockLoc);
      end
      end_row();
      begin_row(4'd9);
      n_cmp++;
      if (bus.newBlockLoc !== 8'hFF) begin
         n_bad++;
         $display("FAIL len9_load: got %b want 11111111", bus.newBlockLoc);
      end
      repeat (3) tick();
      n_cmp++;
      if (bus.newBlockLoc !== 8'hFF) begin
         n_bad++;
         $display("FAIL len9_static: got %b want 11111111", bus.newBlockLoc);
      end
      end_row();
      begin_row(4'd8);
      tick();
      n_cmp++;
      if (bus.newBlockLoc !== 8'hFF) begin
         n_bad++;
         $display("FAIL len8_static: got %b want 11111111", bus.newBlockLoc);
      end
      end_row();
   endtask
   initial begin
      test_reset();
      test_sweep();
      test_stop_hit(8'b00011110, 8'b00011100, 4'd3);
      test_stop_hit(8'b00001111, 8'b00001100, 4'd2);
      test_miss();
      test_stop_edge();
      test_abort_reset_clamp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
